// File: rtl/step_pulse_shaper_if.sv
// Bundles the executor-facing request, timing and status signals of step_pulse_shaper.
// Optional macro STEP_POSITION_EN adds the signed 64-bit position output.
interface step_pulse_shaper_if #(
   parameter int PEND_BITS = 4,
   parameter int TIME_BITS = 8
);
   logic                 step_req;
   logic                 dir_req;
   logic                 enable;
   logic [TIME_BITS-1:0] dir_setup_cycles;
   logic [TIME_BITS-1:0] pulse_high_cycles;
   logic [TIME_BITS-1:0] pulse_low_cycles;
   logic                 clear_overflow;
   logic                 step;
   logic                 dir;
   logic                 busy;
   logic [PEND_BITS:0]   pending;
   logic                 overflow;
`ifdef STEP_POSITION_EN
   logic signed [63:0]   position;

   modport master (
      output step_req, dir_req, enable, dir_setup_cycles, pulse_high_cycles,
             pulse_low_cycles, clear_overflow,
      input  step, dir, busy, pending, overflow, position
   );
   modport slave (
      input  step_req, dir_req, enable, dir_setup_cycles, pulse_high_cycles,
             pulse_low_cycles, clear_overflow,
      output step, dir, busy, pending, overflow, position
   );
`else
   modport master (
      output step_req, dir_req, enable, dir_setup_cycles, pulse_high_cycles,
             pulse_low_cycles, clear_overflow,
      input  step, dir, busy, pending, overflow
   );
   modport slave (
      input  step_req, dir_req, enable, dir_setup_cycles, pulse_high_cycles,
             pulse_low_cycles, clear_overflow,
      output step, dir, busy, pending, overflow
   );
`endif
endinterface

// File: rtl/step_pulse_shaper.sv
// Turns single-cycle step strobes into timed step/dir pulses with a direction FIFO.
// Optional macro STEP_POSITION_EN adds a signed 64-bit position counter.
module step_pulse_shaper #(
   parameter int PEND_BITS = 4,
   parameter int TIME_BITS = 8
) (
   input logic              CLK,
   input logic              reset,
   step_pulse_shaper_if.slave bus
);
   localparam int DEPTH = 2 ** PEND_BITS;
   localparam logic [PEND_BITS:0] FULL_COUNT = (PEND_BITS + 1)'(DEPTH);
   localparam logic [TIME_BITS-1:0] ONE = TIME_BITS'(1);

   typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

   state_t               state_q, state_d;
   logic [TIME_BITS-1:0] timer_q, timer_d;
   logic                 step_q, step_d;
   logic                 dir_q, dir_d;
   logic                 overflow_q, overflow_d;
   logic                 req_q, req_d;
   logic                 req_dir_q, req_dir_d;
   logic [PEND_BITS-1:0] head_q, head_d;
   logic [PEND_BITS-1:0] tail_q, tail_d;
   logic [PEND_BITS:0]   count_q, count_d;
   logic                 queue_mem [DEPTH];

   logic                 pop;
   logic                 push_ok;
   logic                 drop;
   logic                 head_dir;
   logic [TIME_BITS-1:0] eff_setup, eff_high, eff_low;

   // A zero timing input still yields a one-cycle phase.
   assign eff_setup = (bus.dir_setup_cycles  == '0) ? ONE : bus.dir_setup_cycles;
   assign eff_high  = (bus.pulse_high_cycles == '0) ? ONE : bus.pulse_high_cycles;
   assign eff_low   = (bus.pulse_low_cycles  == '0) ? ONE : bus.pulse_low_cycles;

   assign head_dir = queue_mem[head_q];

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      step_d  = step_q;
      dir_d   = dir_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.enable && (count_q != '0)) begin
               pop = 1'b1;
               if (head_dir != dir_q) begin
                  dir_d   = head_dir;
                  timer_d = eff_setup;
                  state_d = SETUP;
               end else begin
                  step_d  = 1'b1;
                  timer_d = eff_high;
                  state_d = HIGH;
               end
            end
         end
         SETUP: begin
            if (timer_q <= ONE) begin
               step_d  = 1'b1;
               timer_d = eff_high;
               state_d = HIGH;
            end else begin
               timer_d = timer_q - ONE;
            end
         end
         HIGH: begin
            if (timer_q <= ONE) begin
               step_d  = 1'b0;
               timer_d = eff_low;
               state_d = LOW;
            end else begin
               timer_d = timer_q - ONE;
            end
         end
         LOW: begin
            if (timer_q <= ONE) begin
               timer_d = '0;
               state_d = IDLE;
            end else begin
               timer_d = timer_q - ONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Requests are registered once before entering the queue; a full queue
   // still accepts when the head leaves in the same cycle.
   always_comb begin
      req_d     = bus.step_req;
      req_dir_d = bus.dir_req;
      push_ok   = req_q && ((count_q != FULL_COUNT) || pop);
      drop      = req_q && !push_ok;
      head_d    = pop ? head_q + 1'b1 : head_q;
      tail_d    = push_ok ? tail_q + 1'b1 : tail_q;
      count_d   = count_q;
      if (push_ok && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push_ok) begin
         count_d = count_q - 1'b1;
      end
      overflow_d = overflow_q;
      if (drop) begin
         overflow_d = 1'b1;
      end else if (bus.clear_overflow) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (push_ok) begin
         queue_mem[tail_q] <= req_dir_q;
      end
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         step_q     <= 1'b0;
         dir_q      <= 1'b0;
         overflow_q <= 1'b0;
         req_q      <= 1'b0;
         req_dir_q  <= 1'b0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         step_q     <= step_d;
         dir_q      <= dir_d;
         overflow_q <= overflow_d;
         req_q      <= req_d;
         req_dir_q  <= req_dir_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
      end
   end

`ifdef STEP_POSITION_EN
   logic signed [63:0] position_q, position_d;

   // dir is already settled whenever step is about to rise.
   always_comb begin
      position_d = position_q;
      if (step_d && !step_q) begin
         position_d = dir_q ? position_q + 64'sd1 : position_q - 64'sd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         position_q <= '0;
      end else begin
         position_q <= position_d;
      end
   end

   assign bus.position = position_q;
`endif

   assign bus.step     = step_q;
   assign bus.dir      = dir_q;
   assign bus.overflow = overflow_q;
   assign bus.pending  = count_q;
   assign bus.busy     = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_step_pulse_shaper.sv
// Bench for step_pulse_shaper: per-cycle waveform model plus directed timing pins.
// Honours STEP_POSITION_EN when the design is built with it.
module tb_step_pulse_shaper;
   localparam int PB    = 4;
   localparam int TW    = 8;
   localparam int DEPTH = 2 ** PB;

   logic CLK = 1'b0;
   logic reset = 1'b1;
   always #5 CLK = ~CLK;

   step_pulse_shaper_if #(.PEND_BITS(PB), .TIME_BITS(TW)) bus ();
   step_pulse_shaper #(.PEND_BITS(PB), .TIME_BITS(TW)) dut (
      .CLK   (CLK),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Model: each popped step expands into a list of per-cycle output slots.
   typedef struct packed {
      logic step;
      logic dir;
      logic active;
   } slot_t;

   slot_t  wave[$];
   bit     mq[$];
   bit     m_req, m_req_dir, m_step, m_dir, m_active, m_ovf;
   bit     armed = 0;
   longint m_pos;

   int  last_rise = -1, last_fall = -1, last_period = -1, last_dir_chg = -1;
   int  rise_count = 0;
   bit  prev_step = 0, prev_dir = 0;

   function automatic int eff(input logic [TW-1:0] v);
      return (v == 0) ? 1 : int'(v);
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic model_edge();
      bit    pop, drop, h;
      slot_t cur;
      cyc++;
      if (reset) begin
         wave.delete();
         mq.delete();
         m_req = 0; m_req_dir = 0; m_step = 0; m_dir = 0; m_active = 0;
         m_ovf = 0; m_pos = 0;
         armed = 1;
         return;
      end
      pop = (wave.size() == 0) && bus.enable && (mq.size() > 0);
      if (pop) begin
         h = mq.pop_front();
         if (h != m_dir) repeat (eff(bus.dir_setup_cycles)) wave.push_back('{1'b0, h, 1'b1});
         repeat (eff(bus.pulse_high_cycles)) wave.push_back('{1'b1, h, 1'b1});
         repeat (eff(bus.pulse_low_cycles)) wave.push_back('{1'b0, h, 1'b1});
         wave.push_back('{1'b0, h, 1'b0});
      end
      drop = 0;
      if (m_req) begin
         if (mq.size() < DEPTH) mq.push_back(m_req_dir);
         else drop = 1;
      end
      if (drop) m_ovf = 1;
      else if (bus.clear_overflow) m_ovf = 0;
      m_req = bus.step_req;
      m_req_dir = bus.dir_req;
      if (wave.size() > 0) begin
         cur = wave.pop_front();
         if (cur.step && !m_step) m_pos = cur.dir ? m_pos + 1 : m_pos - 1;
         m_step = cur.step;
         m_dir = cur.dir;
         m_active = cur.active;
      end else begin
         m_step = 0;
         m_active = 0;
      end
   endtask

   initial forever begin
      @(posedge CLK);
      model_edge();
   end

   initial forever begin
      @(negedge CLK);
      if (armed) begin
         check("step", bus.step, m_step);
         check("dir", bus.dir, m_dir);
         check("busy", bus.busy, m_active || (mq.size() != 0));
         check("pending", bus.pending, mq.size());
         check("overflow", bus.overflow, m_ovf);
`ifdef STEP_POSITION_EN
         check("position", bus.position, m_pos);
`endif
         if (bus.step && !prev_step) begin
            if (last_rise >= 0) last_period = cyc - last_rise;
            last_rise = cyc;
            rise_count++;
         end
         if (!bus.step && prev_step) last_fall = cyc;
         if (bus.dir != prev_dir) last_dir_chg = cyc;
         prev_step = bus.step;
         prev_dir = bus.dir;
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(negedge CLK);
         #1;
      end
   endtask

   task automatic set_timing(input int s, input int h, input int l);
      bus.dir_setup_cycles  = TW'(s);
      bus.pulse_high_cycles = TW'(h);
      bus.pulse_low_cycles  = TW'(l);
   endtask

   task automatic strobe(input bit d);
      bus.step_req = 1;
      bus.dir_req = d;
      tick();
      bus.step_req = 0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int k = 0;
      while ((wave.size() != 0 || mq.size() != 0 || m_req) && k < budget) begin
         tick();
         k++;
      end
      check(name, k < budget, 1);
   endtask

   task automatic wait_step_high(input string name);
      int k = 0;
      while (!bus.step && k < 200) begin
         tick();
         k++;
      end
      check(name, k < 200, 1);
   endtask

   initial begin
      int n, r0;
      bus.step_req = 0; bus.dir_req = 0; bus.enable = 0; bus.clear_overflow = 0;
      set_timing(3, 4, 5);
      tick(3);
      check("rst_pending", bus.pending, 0);
      check("rst_step", bus.step, 0);
      check("rst_overflow", bus.overflow, 0);
      reset = 0;
      bus.enable = 1;
      tick(2);

      // Single step, matching direction: rise two edges after sampling.
      n = cyc; r0 = rise_count;
      strobe(0);
      wait_idle("idle_t1", 100);
      check("t1_latency", last_rise - n, 3);
      check("t1_high_width", last_fall - last_rise, 4);
      check("t1_pulses", rise_count - r0, 1);
      check("t1_dir", bus.dir, 0);
      check("t1_busy", bus.busy, 0);

      // Direction change inserts the setup time before the rise.
      n = cyc;
      strobe(1);
      wait_idle("idle_t2", 100);
      check("t2_dir_change", last_dir_chg - n, 3);
      check("t2_rise", last_rise - n, 6);
      check("t2_dir_final", bus.dir, 1);

      // All timing inputs zero: period 3.
      set_timing(0, 0, 0);
      r0 = rise_count;
      repeat (3) strobe(1);
      wait_idle("idle_t3", 100);
      check("t3_pulses", rise_count - r0, 3);
      check("t3_period", last_period, 3);

      // Fill the queue while paused, drop extras, then set-wins on clear.
      bus.enable = 0;
      set_timing(0, 2, 2);
      repeat (20) strobe(1);
      tick(2);
      check("t4_pending_full", bus.pending, DEPTH);
      check("t4_overflow", bus.overflow, 1);
      bus.step_req = 1; bus.dir_req = 1;
      tick();
      bus.step_req = 0; bus.clear_overflow = 1;
      tick();
      bus.clear_overflow = 0;
      tick();
      check("t4_set_wins", bus.overflow, 1);
      bus.clear_overflow = 1;
      tick();
      bus.clear_overflow = 0;
      tick();
      check("t4_cleared", bus.overflow, 0);
      r0 = rise_count;
      bus.enable = 1;
      wait_idle("idle_t4", 400);
      check("t4_pulses", rise_count - r0, DEPTH);
      check("t4_period", last_period, 5);

      // Pause during HIGH: current pulse finishes, queue held.
      set_timing(0, 6, 2);
      r0 = rise_count;
      repeat (4) strobe(1);
      wait_step_high("t5_wait_high");
      bus.enable = 0;
      tick(20);
      check("t5_pending_held", bus.pending, 3);
      check("t5_one_pulse", rise_count - r0, 1);
      check("t5_step_low", bus.step, 0);
      bus.enable = 1;
      wait_idle("idle_t5", 200);
      check("t5_resume", rise_count - r0, 4);

      // Reset mid-HIGH with five pending.
      set_timing(0, 10, 2);
      repeat (6) strobe(1);
      wait_step_high("t6_wait_high");
      tick(2);
      check("t6_pending5", bus.pending, 5);
      reset = 1;
      tick();
      check("t6_step", bus.step, 0);
      check("t6_pending", bus.pending, 0);
      check("t6_busy", bus.busy, 0);
`ifdef STEP_POSITION_EN
      check("t6_position", bus.position, 0);
`endif
      reset = 0;
      tick();

      // Randomised traffic against the model.
      for (int seg = 0; seg < 8; seg++) begin
         int k;
         bus.enable = 0;
         bus.step_req = 0;
         k = 0;
         while ((wave.size() != 0 || m_req) && k < 300) begin
            tick();
            k++;
         end
         check("rand_settle", k < 300, 1);
         set_timing($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4));
         bus.enable = 1;
         for (int i = 0; i < 400; i++) begin
            bus.step_req = ($urandom_range(0, 2) == 0);
            bus.dir_req = $urandom_range(0, 1);
            bus.clear_overflow = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 19) == 0) bus.enable = ~bus.enable;
            reset = ($urandom_range(0, 299) == 0);
            tick();
         end
         bus.step_req = 0;
         bus.clear_overflow = 0;
         reset = 0;
      end
      bus.enable = 1;
      wait_idle("final_idle", 3000);
      tick(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
